// File: rtl/snake_sound_sched.sv
`default_nettype none
// snake_sound_sched: shares one buzzer among eat/level/game-over beep patterns.
// Revision 1.0 - initial release.
module snake_sound_sched #(
  parameter int TICK_DIV = 50_000,
  parameter int TONE_DIV = 12_500,
  parameter int EAT_MS   = 100,
  parameter int LVL_MS   = 80,
  parameter int OVER_MS  = 300,
  parameter int GAP_MS   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eat_req,
  input  logic       lvl_req,
  input  logic       over_req,
  input  logic [1:0] game_status,
  input  logic       mute,
  output logic       beep,
  output logic       tone,
  output logic       busy,
  output logic [1:0] active_id
);

  localparam int c_max_a  = (EAT_MS > LVL_MS) ? EAT_MS : LVL_MS;
  localparam int c_max_b  = (OVER_MS > GAP_MS) ? OVER_MS : GAP_MS;
  localparam int c_max_ms = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_sub_w  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_ms_w   = (c_max_ms > 1) ? $clog2(c_max_ms) : 1;
  localparam int c_tone_w = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [c_sub_w-1:0]  c_sub_last  = c_sub_w'(TICK_DIV - 1);
  localparam logic [c_tone_w-1:0] c_tone_last = c_tone_w'(TONE_DIV - 1);
  localparam logic [c_ms_w-1:0]   c_eat_m1    = c_ms_w'(EAT_MS - 1);
  localparam logic [c_ms_w-1:0]   c_lvl_m1    = c_ms_w'(LVL_MS - 1);
  localparam logic [c_ms_w-1:0]   c_over_m1   = c_ms_w'(OVER_MS - 1);
  localparam logic [c_ms_w-1:0]   c_gap_m1    = c_ms_w'(GAP_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          req_q, pend_q, pend_d;
  logic [c_sub_w-1:0]  sub_q, sub_d;
  logic [c_ms_w-1:0]   ms_q, ms_d, len_q, len_d;
  logic [c_tone_w-1:0] tdiv_q, tdiv_d;
  logic                tone_q, tone_d;
  logic [1:0]          left_q, left_d, active_q, active_d;
  logic [2:0]          w_req, w_rise, w_grant;
  logic                w_take;

  // Request vectors are ordered {over, lvl, eat}.
  assign w_req  = {over_req, lvl_req, eat_req};
  assign w_rise = w_req & ~req_q;
  assign w_take = ((state_q == S_IDLE) && (|pend_q)) ||
                  (pend_q[2] && ((active_q == 2'd1) || (active_q == 2'd2)));

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    ms_d     = ms_q;
    len_d    = len_q;
    tdiv_d   = tdiv_q;
    tone_d   = tone_q;
    left_d   = left_q;
    active_d = active_q;
    w_grant  = 3'b000;
    pend_d   = pend_q;

    unique case (state_q)
      S_ON: begin
        if (tdiv_q == c_tone_last) begin
          tdiv_d = '0;
          tone_d = ~tone_q;
        end else begin
          tdiv_d = tdiv_q + c_tone_w'(1);
        end
        if (sub_q == c_sub_last) begin
          sub_d = '0;
          if (ms_q == len_q) begin
            ms_d    = '0;
            tdiv_d  = '0;
            tone_d  = 1'b0;
            state_d = S_GAP;
          end else begin
            ms_d = ms_q + c_ms_w'(1);
          end
        end else begin
          sub_d = sub_q + c_sub_w'(1);
        end
      end
      S_GAP: begin
        if (sub_q == c_sub_last) begin
          sub_d = '0;
          if (ms_q == c_gap_m1) begin
            ms_d = '0;
            if (left_q != 2'd0) begin
              left_d  = left_q - 2'd1;
              tdiv_d  = '0;
              tone_d  = 1'b1;
              state_d = S_ON;
            end else begin
              active_d = 2'd0;
              state_d  = S_IDLE;
            end
          end else begin
            ms_d = ms_q + c_ms_w'(1);
          end
        end else begin
          sub_d = sub_q + c_sub_w'(1);
        end
      end
      default: ;
    endcase

    // A grant from IDLE and a game-over preemption share one load path.
    if (w_take) begin
      state_d = S_ON;
      sub_d   = '0;
      ms_d    = '0;
      tdiv_d  = '0;
      tone_d  = 1'b1;
      if (pend_q[2]) begin
        w_grant  = 3'b100;
        active_d = 2'd3;
        left_d   = 2'd2;
        len_d    = c_over_m1;
      end else if (pend_q[1]) begin
        w_grant  = 3'b010;
        active_d = 2'd2;
        left_d   = 2'd1;
        len_d    = c_lvl_m1;
      end else begin
        w_grant  = 3'b001;
        active_d = 2'd1;
        left_d   = 2'd0;
        len_d    = c_eat_m1;
      end
    end
    pend_d = (pend_q & ~w_grant) | w_rise;

    if (game_status == 2'b00) begin
      state_d  = S_IDLE;
      pend_d   = '0;
      sub_d    = '0;
      ms_d     = '0;
      len_d    = '0;
      tdiv_d   = '0;
      tone_d   = 1'b0;
      left_d   = '0;
      active_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      pend_q   <= '0;
      sub_q    <= '0;
      ms_q     <= '0;
      len_q    <= '0;
      tdiv_q   <= '0;
      tone_q   <= 1'b0;
      left_q   <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= w_req;
      pend_q   <= pend_d;
      sub_q    <= sub_d;
      ms_q     <= ms_d;
      len_q    <= len_d;
      tdiv_q   <= tdiv_d;
      tone_q   <= tone_d;
      left_q   <= left_d;
      active_q <= active_d;
    end
  end

  assign beep      = (state_q == S_ON) & ~mute;
  assign tone      = tone_q & ~mute;
  assign busy      = (state_q != S_IDLE);
  assign active_id = active_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_sound_sched.sv
`default_nettype none
// tb_snake_sound_sched: directed checks of the buzzer scheduler with small timing parameters.
// Revision 1.0 - initial release.
module tb_snake_sound_sched;

  logic       clk;
  logic       rst;
  logic       eat_req, lvl_req, over_req;
  logic [1:0] game_status;
  logic       mute;
  logic       beep, tone, busy;
  logic [1:0] active_id;

  int total = 0;
  int bad   = 0;

  // Observation accumulators over a window of edges.
  int          nb, nbusy, nrise, nover, tidx;
  logic        prev_beep;
  logic [63:0] tone_v;

  snake_sound_sched #(
    .TICK_DIV(4), .TONE_DIV(2), .EAT_MS(3), .LVL_MS(2), .OVER_MS(5), .GAP_MS(2)
  ) dut (
    .clk(clk), .rst(rst), .eat_req(eat_req), .lvl_req(lvl_req), .over_req(over_req),
    .game_status(game_status), .mute(mute), .beep(beep), .tone(tone), .busy(busy),
    .active_id(active_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    nb = 0; nbusy = 0; nrise = 0; nover = 0; tidx = 0;
    tone_v = '0;
    prev_beep = beep;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (beep) nb++;
      if (busy) nbusy++;
      if (active_id == 2'd3) nover++;
      if (beep && !prev_beep) nrise++;
      if (tidx < 64) tone_v[tidx] = tone;
      tidx++;
      prev_beep = beep;
    end
  endtask

  initial begin
    rst = 1'b1; eat_req = 1'b1; lvl_req = 1'b0; over_req = 1'b0;
    game_status = 2'b01; mute = 1'b0;

    // Reset held for three edges with eat_req high.
    run(3);
    chk("rst_beep", beep, 0);
    chk("rst_tone", tone, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active", active_id, 0);
    rst = 1'b0;
    run(1);
    chk("rst_rel_pend_only", busy, 0);
    clr();
    run(1);
    chk("rst_rel_active", active_id, 1);
    chk("rst_rel_beep", beep, 1);
    run(29);
    chk("rst_rel_beep_cycles", nb, 12);
    chk("rst_rel_busy_cycles", nbusy, 20);
    chk("rst_rel_pulses", nrise, 1);
    clr();
    run(8);
    chk("rst_held_no_repeat", nbusy, 0);
    eat_req = 1'b0;
    run(2);

    // Single eat pulse with tone pattern.
    eat_req = 1'b1;
    run(1);
    eat_req = 1'b0;
    chk("eat_k_beep", beep, 0);
    chk("eat_k_busy", busy, 0);
    clr();
    run(1);
    chk("eat_active", active_id, 1);
    chk("eat_tone_first", tone, 1);
    run(23);
    chk("eat_beep_cycles", nb, 12);
    chk("eat_busy_cycles", nbusy, 20);
    chk("eat_tone_pattern", tone_v[23:0], 32'h000333);
    chk("eat_end_active", active_id, 0);
    chk("eat_end_busy", busy, 0);

    // Simultaneous lvl and eat, plus two more eat pulses during service.
    lvl_req = 1'b1; eat_req = 1'b1;
    run(1);
    lvl_req = 1'b0; eat_req = 1'b0;
    clr();
    run(1);
    chk("sim_first_lvl", active_id, 2);
    run(5);
    eat_req = 1'b1; run(1); eat_req = 1'b0;
    run(5);
    eat_req = 1'b1; run(1); eat_req = 1'b0;
    run(19);
    chk("sim_lvl_last_gap", active_id, 2);
    run(1);
    chk("sim_idle_between", busy, 0);
    run(1);
    chk("sim_then_eat", active_id, 1);
    run(26);
    chk("sim_beep_cycles", nb, 28);
    chk("sim_busy_cycles", nbusy, 52);
    chk("sim_pulses", nrise, 3);
    chk("sim_end_busy", busy, 0);

    // Game-over preempts an eat pattern during its ON phase.
    eat_req = 1'b1;
    run(1);
    eat_req = 1'b0;
    run(4);
    chk("pre_eat_on", beep, 1);
    over_req = 1'b1;
    run(1);
    over_req = 1'b0;
    chk("pre_pend_edge_active", active_id, 1);
    clr();
    run(1);
    chk("pre_active_over", active_id, 3);
    chk("pre_beep_stays", beep, 1);
    chk("pre_tone_restart", tone, 1);
    run(90);
    chk("pre_busy_cycles", nbusy, 84);
    chk("pre_over_cycles", nover, 84);
    chk("pre_beep_cycles", nb, 60);
    chk("pre_new_rises", nrise, 2);
    chk("pre_no_eat_replay", busy, 0);

    // Mute silences outputs while sequencing continues.
    mute = 1'b1;
    eat_req = 1'b1;
    run(1);
    eat_req = 1'b0;
    clr();
    run(24);
    chk("mute_beep", nb, 0);
    chk("mute_tone", tone_v[23:0], 0);
    chk("mute_busy", nbusy, 20);
    mute = 1'b0;

    // game_status idle aborts a pattern and flushes pending requests.
    eat_req = 1'b1;
    run(1);
    eat_req = 1'b0;
    run(3);
    chk("gs_running", active_id, 1);
    lvl_req = 1'b1;
    run(1);
    lvl_req = 1'b0;
    game_status = 2'b00;
    run(1);
    chk("gs_busy_drop", busy, 0);
    chk("gs_active_drop", active_id, 0);
    game_status = 2'b01;
    clr();
    run(12);
    chk("gs_pend_cleared", nbusy, 0);

    // Over rise during idle game status is discarded.
    game_status = 2'b00;
    over_req = 1'b1;
    run(1);
    over_req = 1'b0;
    run(1);
    game_status = 2'b01;
    clr();
    run(12);
    chk("gs_over_discarded", nbusy, 0);
    over_req = 1'b1;
    run(1);
    over_req = 1'b0;
    run(1);
    chk("gs_over_after_resume", active_id, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
